// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The optional wait-cycle counters are enabled with DMEM_ARB_PERF_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_CORE, OWN_DMA} owner_t;

  localparam logic [1:0] CTRL_NONE = 2'b00;
  localparam logic [1:0] CTRL_RD   = 2'b10;
  localparam logic [1:0] CTRL_WR   = 2'b01;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic core_req,
  input  logic dma_req,
  input  logic take,
  output logic core_win,
  output logic dma_win
);

  owner_t last_gnt;

  // Reset value OWN_DMA makes the core win the first tie.
  always_comb begin
    core_win = core_req && (!dma_req || last_gnt == OWN_DMA);
    dma_win  = dma_req && !core_win;
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_gnt <= OWN_DMA;
    else if (take)
      last_gnt <= core_win ? OWN_CORE : OWN_DMA;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core MEM stage and DMA.
// Define DMEM_ARB_PERF_EN to add per-requester wait-cycle counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef DMEM_ARB_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_coreReq,
  input  logic              i_coreWe,
  input  logic [ADDR_W-1:0] i_coreAddr,
  input  logic [DATA_W-1:0] i_coreWdata,
  output logic              o_coreGnt,
  output logic              o_coreRvalid,
  output logic [DATA_W-1:0] o_coreRdata,
  output logic              o_coreErr,
  input  logic              i_dmaReq,
  input  logic              i_dmaWe,
  input  logic [ADDR_W-1:0] i_dmaAddr,
  input  logic [DATA_W-1:0] i_dmaWdata,
  output logic              o_dmaGnt,
  output logic              o_dmaRvalid,
  output logic [DATA_W-1:0] o_dmaRdata,
  output logic              o_dmaErr,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memWdata,
  output logic [1:0]        o_ctrlMEM,
  input  logic [DATA_W-1:0] i_readData,
  output logic              o_busy
`ifdef DMEM_ARB_PERF_EN
  , output logic [PERF_W-1:0] o_coreWaitCnt
  , output logic [PERF_W-1:0] o_dmaWaitCnt
`endif
);

  state_t state;
  owner_t owner;
  logic   we_q, err_q;

  logic              core_win, dma_win, grant;
  logic              sel_we, sel_mis;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_pass;

  // Grant is combinational so it lands in the same cycle the request is sampled.
  assign grant = (state == IDLE) && (i_coreReq || i_dmaReq) && !i_reset;

  dmem_arb_rr u_rr (
    .clk      (i_clk),
    .reset    (i_reset),
    .core_req (i_coreReq),
    .dma_req  (i_dmaReq),
    .take     (grant),
    .core_win (core_win),
    .dma_win  (dma_win)
  );

  assign o_coreGnt = grant && core_win;
  assign o_dmaGnt  = grant && dma_win;

  always_comb begin
    sel_we    = core_win ? i_coreWe    : i_dmaWe;
    sel_addr  = core_win ? i_coreAddr  : i_dmaAddr;
    sel_wdata = core_win ? i_coreWdata : i_dmaWdata;
    sel_mis   = misaligned(sel_addr[1:0]);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      owner        <= OWN_CORE;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      o_memAddr    <= '0;
      o_memWdata   <= '0;
      o_ctrlMEM    <= CTRL_NONE;
      o_coreRvalid <= 1'b0;
      o_dmaRvalid  <= 1'b0;
      o_coreErr    <= 1'b0;
      o_dmaErr     <= 1'b0;
    end else begin
      o_ctrlMEM    <= CTRL_NONE;
      o_coreRvalid <= 1'b0;
      o_dmaRvalid  <= 1'b0;
      o_coreErr    <= 1'b0;
      o_dmaErr     <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          owner <= core_win ? OWN_CORE : OWN_DMA;
          we_q  <= sel_we;
          err_q <= sel_mis;
          if (sel_mis) begin
            // Misaligned: skip the memory entirely and report the error.
            state        <= RESP;
            o_coreRvalid <= core_win;
            o_dmaRvalid  <= dma_win;
            o_coreErr    <= core_win;
            o_dmaErr     <= dma_win;
          end else begin
            state      <= ACCESS;
            o_memAddr  <= sel_addr;
            o_memWdata <= sel_wdata;
            o_ctrlMEM  <= sel_we ? CTRL_WR : CTRL_RD;
          end
        end
        ACCESS: begin
          state        <= RESP;
          o_coreRvalid <= (owner == OWN_CORE);
          o_dmaRvalid  <= (owner == OWN_DMA);
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory data arrives during RESP, so read data is steered through, not registered.
  assign rd_pass     = !we_q && !err_q;
  assign o_coreRdata = (o_coreRvalid && rd_pass) ? i_readData : '0;
  assign o_dmaRdata  = (o_dmaRvalid  && rd_pass) ? i_readData : '0;
  assign o_busy      = (state != IDLE);

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_coreWaitCnt <= '0;
      o_dmaWaitCnt  <= '0;
    end else begin
      if (i_coreReq && !o_coreGnt && o_coreWaitCnt != '1)
        o_coreWaitCnt <= o_coreWaitCnt + 1'b1;
      if (i_dmaReq && !o_dmaGnt && o_dmaWaitCnt != '1)
        o_dmaWaitCnt <= o_dmaWaitCnt + 1'b1;
    end
  end
`endif

endmodule
